cache_req_arbiter: RTL and testbench

Round-robin front-end controller that shares the single cache_top request port between two requesters (instruction-side and data-side trace streams). It accepts one request at a time, presents it to the cache with a valid/ready handshake, waits for completion, and routes the hit/miss result back to the originator. It also holds the cache policy configuration stable while a transaction is in flight and keeps per-requester grant and hit statistics.

---
 rtl/cache_req_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_cache_req_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter
//   Round-robin front end that shares the single cache request port between
//   two requesters. One transaction is outstanding at a time. The FSM runs
//   IDLE -> ISSUE -> WAIT -> IDLE. The hit/miss result, or a timeout error,
//   is routed back to the requester that issued the request as a one-cycle
//   pulse. Policy configuration is sampled only in IDLE, so it stays stable
//   while a transaction is in flight. Per-requester grant and hit counters
//   saturate at their maximum value.
//
// Ports
//   clk, reset                         clock; synchronous active-high reset
//   req{0,1}_valid/_addr/_we           request inputs from each requester
//   req{0,1}_ready                     accept strobe (IDLE and granted)
//   rsp{0,1}_valid, rsp_hit, rsp_err   registered completion pulse and flags
//   cache_valid/_addr/_we, cache_ready request handshake to the cache
//   cache_done, cache_hit              completion from the cache
//   cfg_*_policy -> *_policy           policy passthrough, frozen when busy
//   grant{0,1}_count, hit{0,1}_count   saturating statistics
module cache_req_arbiter #(
  parameter int unsigned ADDR_W  = 48,
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_we,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_we,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic              cache_valid,
  input  logic              cache_ready,
  output logic [ADDR_W-1:0] cache_addr,
  output logic              cache_we,
  input  logic              cache_done,
  input  logic              cache_hit,
  input  logic              cfg_write_policy,
  input  logic              cfg_replace_policy,
  input  logic [1:0]        cfg_inclusion_policy,
  output logic              write_policy,
  output logic              replace_policy,
  output logic [1:0]        inclusion_policy,
  output logic [CNT_W-1:0]  grant0_count,
  output logic [CNT_W-1:0]  grant1_count,
  output logic [CNT_W-1:0]  hit0_count,
  output logic [CNT_W-1:0]  hit1_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic                rr_last_q;
  logic                src_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [7:0]          timer_q;
  logic                rsp0_q, rsp1_q, hit_q, err_q;
  logic                wp_q, rp_q;
  logic [1:0]          ip_q;
  logic [CNT_W-1:0]    grant0_q, grant1_q, hit0_q, hit1_q;

  logic                grant0, grant1, accept0, accept1;
  logic [CNT_W-1:0]    grant0_d, grant1_d, hit0_d, hit1_d;

  // On a tie, the requester that was not served last wins.
  always_comb begin
    grant0  = req0_valid & (~req1_valid | rr_last_q);
    grant1  = req1_valid & (~req0_valid | ~rr_last_q);
    accept0 = req0_valid & req0_ready;
    accept1 = req1_valid & req1_ready;
  end

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;

  // Saturating increments.
  always_comb begin
    grant0_d = (&grant0_q) ? grant0_q : grant0_q + CNT_ONE;
    grant1_d = (&grant1_q) ? grant1_q : grant1_q + CNT_ONE;
    hit0_d   = (&hit0_q)   ? hit0_q   : hit0_q   + CNT_ONE;
    hit1_d   = (&hit1_q)   ? hit1_q   : hit1_q   + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      src_q     <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      timer_q   <= '0;
      rsp0_q    <= 1'b0;
      rsp1_q    <= 1'b0;
      hit_q     <= 1'b0;
      err_q     <= 1'b0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      ip_q      <= '0;
      grant0_q  <= '0;
      grant1_q  <= '0;
      hit0_q    <= '0;
      hit1_q    <= '0;
    end else begin
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      hit_q  <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          wp_q <= cfg_write_policy;
          rp_q <= cfg_replace_policy;
          ip_q <= cfg_inclusion_policy;
          if (accept0) begin
            addr_q   <= req0_addr;
            we_q     <= req0_we;
            src_q    <= 1'b0;
            grant0_q <= grant0_d;
            state_q  <= ISSUE;
          end else if (accept1) begin
            addr_q   <= req1_addr;
            we_q     <= req1_we;
            src_q    <= 1'b1;
            grant1_q <= grant1_d;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (cache_ready) begin
            timer_q <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // A completion in the final timer cycle takes precedence over timeout.
          if (cache_done) begin
            rsp0_q    <= ~src_q;
            rsp1_q    <= src_q;
            hit_q     <= cache_hit;
            if (cache_hit && !src_q) hit0_q <= hit0_d;
            if (cache_hit &&  src_q) hit1_q <= hit1_d;
            rr_last_q <= src_q;
            state_q   <= IDLE;
          end else if (timer_q == TMO_LAST) begin
            rsp0_q    <= ~src_q;
            rsp1_q    <= src_q;
            err_q     <= 1'b1;
            rr_last_q <= src_q;
            state_q   <= IDLE;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cache_valid      = (state_q == ISSUE);
  assign cache_addr       = addr_q;
  assign cache_we         = we_q;
  assign rsp0_valid       = rsp0_q;
  assign rsp1_valid       = rsp1_q;
  assign rsp_hit          = hit_q;
  assign rsp_err          = err_q;
  assign write_policy     = wp_q;
  assign replace_policy   = rp_q;
  assign inclusion_policy = ip_q;
  assign grant0_count     = grant0_q;
  assign grant1_count     = grant1_q;
  assign hit0_count       = hit0_q;
  assign hit1_count       = hit1_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
module tb_cache_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [47:0] req0_addr, req1_addr;
  logic        cache_ready, cache_done, cache_hit;
  logic        cfg_write_policy, cfg_replace_policy;
  logic [1:0]  cfg_inclusion_policy;

  // default-parameter instance
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_hit, rsp_err;
  logic        cache_valid, cache_we, write_policy, replace_policy;
  logic [47:0] cache_addr;
  logic [1:0]  inclusion_policy;
  logic [11:0] grant0_count, grant1_count, hit0_count, hit1_count;

  // small instance (CNT_W=2, TIMEOUT=4), same stimulus
  logic        sm_req0_ready, sm_req1_ready, sm_rsp0_valid, sm_rsp1_valid, sm_rsp_hit, sm_rsp_err;
  logic        sm_cache_valid, sm_cache_we, sm_write_policy, sm_replace_policy;
  logic [47:0] sm_cache_addr;
  logic [1:0]  sm_inclusion_policy;
  logic [1:0]  sm_grant0_count, sm_grant1_count, sm_hit0_count, sm_hit1_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_req_arbiter u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_we(req0_we),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_we(req1_we),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_hit(rsp_hit), .rsp_err(rsp_err),
    .cache_valid(cache_valid), .cache_ready(cache_ready), .cache_addr(cache_addr), .cache_we(cache_we),
    .cache_done(cache_done), .cache_hit(cache_hit),
    .cfg_write_policy(cfg_write_policy), .cfg_replace_policy(cfg_replace_policy),
    .cfg_inclusion_policy(cfg_inclusion_policy),
    .write_policy(write_policy), .replace_policy(replace_policy), .inclusion_policy(inclusion_policy),
    .grant0_count(grant0_count), .grant1_count(grant1_count),
    .hit0_count(hit0_count), .hit1_count(hit1_count)
  );

  cache_req_arbiter #(.ADDR_W(48), .CNT_W(2), .TIMEOUT(4)) u_sm (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(sm_req0_ready), .req0_addr(req0_addr), .req0_we(req0_we),
    .req1_valid(req1_valid), .req1_ready(sm_req1_ready), .req1_addr(req1_addr), .req1_we(req1_we),
    .rsp0_valid(sm_rsp0_valid), .rsp1_valid(sm_rsp1_valid), .rsp_hit(sm_rsp_hit), .rsp_err(sm_rsp_err),
    .cache_valid(sm_cache_valid), .cache_ready(cache_ready), .cache_addr(sm_cache_addr), .cache_we(sm_cache_we),
    .cache_done(cache_done), .cache_hit(cache_hit),
    .cfg_write_policy(cfg_write_policy), .cfg_replace_policy(cfg_replace_policy),
    .cfg_inclusion_policy(cfg_inclusion_policy),
    .write_policy(sm_write_policy), .replace_policy(sm_replace_policy), .inclusion_policy(sm_inclusion_policy),
    .grant0_count(sm_grant0_count), .grant1_count(sm_grant1_count),
    .hit0_count(sm_hit0_count), .hit1_count(sm_hit1_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_we = 0; req1_we = 0;
    req0_addr = '0; req1_addr = '0;
    cache_ready = 0; cache_done = 0; cache_hit = 0;
    cfg_write_policy = 0; cfg_replace_policy = 0; cfg_inclusion_policy = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++; if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_hit, rsp_err, cache_valid, cache_we} !== 8'h00) begin fails++; $display("FAIL reset_flags: got %b want 00000000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_hit, rsp_err, cache_valid, cache_we}); end
    tests++; if (cache_addr !== 48'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", cache_addr); end
    tests++; if ({grant0_count, grant1_count, hit0_count, hit1_count} !== 48'h0) begin fails++; $display("FAIL reset_counts: got %h want 0", {grant0_count, grant1_count, hit0_count, hit1_count}); end
    tests++; if ({write_policy, replace_policy, inclusion_policy} !== 4'h0) begin fails++; $display("FAIL reset_policy: got %b want 0000", {write_policy, replace_policy, inclusion_policy}); end
    req0_valid = 1;
    #1;
    tests++; if ({req0_ready, req1_ready} !== 2'b10) begin fails++; $display("FAIL reset_ready_comb: got %b want 10", {req0_ready, req1_ready}); end
    // withdraw before the edge: no acceptance
    req0_valid = 0;
    step();
    tests++; if ({cache_valid, grant0_count} !== 13'h0) begin fails++; $display("FAIL drop_valid: got cv=%b g0=%0d want 0,0", cache_valid, grant0_count); end
  endtask

  task automatic test_single_read();
    do_reset();
    req0_valid = 1; req0_addr = 48'h7fff493822b0; req0_we = 0; cache_ready = 1;
    step();                                  // T+1
    req0_valid = 0;
    tests++; if ({cache_valid, cache_we} !== 2'b10 || cache_addr !== 48'h7fff493822b0) begin fails++; $display("FAIL single_issue: got cv=%b we=%b addr=%h want 1,0,7fff493822b0", cache_valid, cache_we, cache_addr); end
    tests++; if (grant0_count !== 12'd1) begin fails++; $display("FAIL single_grant: got %0d want 1", grant0_count); end
    step();                                  // T+2, WAIT
    tests++; if (cache_valid !== 1'b0) begin fails++; $display("FAIL single_wait_cv: got %b want 0", cache_valid); end
    cache_done = 1; cache_hit = 0;
    step();                                  // T+3
    cache_done = 0;
    tests++; if ({rsp0_valid, rsp1_valid, rsp_hit, rsp_err} !== 4'b1000) begin fails++; $display("FAIL single_rsp: got %b want 1000", {rsp0_valid, rsp1_valid, rsp_hit, rsp_err}); end
    step();
    tests++; if ({rsp0_valid, hit0_count} !== 13'h0) begin fails++; $display("FAIL single_after: got rsp0=%b h0=%0d want 0,0", rsp0_valid, hit0_count); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rdy;
    logic [1:0] exp_rsp;
    do_reset();
    req0_valid = 1; req1_valid = 1; req0_addr = 48'h100; req1_addr = 48'h200; cache_ready = 1;
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      tests++; if ({req0_ready, req1_ready} !== exp_rdy) begin fails++; $display("FAIL rr_grant%0d: got %b want %b", i, {req0_ready, req1_ready}, exp_rdy); end
      step();                                // ISSUE
      step();                                // WAIT
      cache_done = 1; cache_hit = 1;
      step();                                // IDLE + response
      cache_done = 0; cache_hit = 0;
      if (i == 3) begin req0_valid = 0; req1_valid = 0; end
      exp_rsp = exp_rdy;
      tests++; if ({rsp0_valid, rsp1_valid, rsp_hit} !== {exp_rsp, 1'b1}) begin fails++; $display("FAIL rr_rsp%0d: got %b want %b1", i, {rsp0_valid, rsp1_valid, rsp_hit}, exp_rsp); end
    end
    step();
    tests++; if ({grant0_count, grant1_count, hit0_count, hit1_count} !== {12'd2, 12'd2, 12'd2, 12'd2}) begin fails++; $display("FAIL rr_counts: got %0d %0d %0d %0d want 2 2 2 2", grant0_count, grant1_count, hit0_count, hit1_count); end
    tests++; if (cache_valid !== 1'b0) begin fails++; $display("FAIL rr_idle: got cv=%b want 0", cache_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    cfg_inclusion_policy = 2'b01; cfg_write_policy = 1;
    #1;
    tests++; if ({write_policy, inclusion_policy} !== 3'b000) begin fails++; $display("FAIL cfg_latency: got %b want 000", {write_policy, inclusion_policy}); end
    req1_valid = 1; req1_addr = 48'h7f3035f6a7c0; req1_we = 1; cache_ready = 0;
    step();                                  // sample cfg, accept req1
    req1_valid = 0; req1_addr = 48'h0;
    cfg_inclusion_policy = 2'b10; cfg_write_policy = 0;
    cache_done = 1;                          // must be ignored in ISSUE
    for (int i = 0; i < 5; i++) begin
      tests++; if ({cache_valid, cache_we} !== 2'b11 || cache_addr !== 48'h7f3035f6a7c0 || {write_policy, inclusion_policy} !== 3'b101) begin fails++; $display("FAIL bp_hold%0d: got cv=%b we=%b addr=%h pol=%b want 1,1,7f3035f6a7c0,101", i, cache_valid, cache_we, cache_addr, {write_policy, inclusion_policy}); end
      step();
    end
    cache_done = 0; cache_ready = 1;
    tests++; if ({cache_valid, rsp1_valid} !== 2'b10) begin fails++; $display("FAIL bp_done_ignored: got cv=%b rsp1=%b want 1,0", cache_valid, rsp1_valid); end
    step();                                  // WAIT
    cache_ready = 0; cache_done = 1; cache_hit = 1;
    tests++; if ({cache_valid, inclusion_policy} !== 3'b001) begin fails++; $display("FAIL bp_wait: got cv=%b ip=%b want 0,01", cache_valid, inclusion_policy); end
    step();                                  // IDLE + response
    cache_done = 0; cache_hit = 0;
    tests++; if ({rsp1_valid, rsp_hit, inclusion_policy} !== 4'b1101) begin fails++; $display("FAIL bp_rsp: got rsp1=%b hit=%b ip=%b want 1,1,01", rsp1_valid, rsp_hit, inclusion_policy); end
    step();
    tests++; if ({write_policy, inclusion_policy} !== 3'b010) begin fails++; $display("FAIL bp_cfg_update: got %b want 010", {write_policy, inclusion_policy}); end
    tests++; if ({grant1_count, hit1_count} !== {12'd1, 12'd1}) begin fails++; $display("FAIL bp_counts: got g1=%0d h1=%0d want 1,1", grant1_count, hit1_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    req0_valid = 1; req0_addr = 48'hABC; cache_ready = 1;
    step();                                  // ISSUE
    req0_valid = 0;
    step();                                  // WAIT, cycle 0
    cache_ready = 0;
    for (int k = 0; k < 4; k++) begin
      tests++; if ({sm_rsp0_valid, sm_rsp1_valid, sm_rsp_err} !== 3'b000) begin fails++; $display("FAIL tmo_early%0d: got %b want 000", k, {sm_rsp0_valid, sm_rsp1_valid, sm_rsp_err}); end
      step();
    end
    tests++; if ({sm_rsp0_valid, sm_rsp1_valid, sm_rsp_hit, sm_rsp_err} !== 4'b1001) begin fails++; $display("FAIL tmo_rsp: got %b want 1001", {sm_rsp0_valid, sm_rsp1_valid, sm_rsp_hit, sm_rsp_err}); end
    tests++; if (rsp0_valid !== 1'b0) begin fails++; $display("FAIL tmo_default_wait: got %b want 0", rsp0_valid); end
    // back in IDLE; requester 0 was served last so requester 1 wins the tie
    req0_valid = 1; req1_valid = 1;
    #1;
    tests++; if ({sm_req0_ready, sm_req1_ready} !== 2'b01) begin fails++; $display("FAIL tmo_idle_rr: got %b want 01", {sm_req0_ready, sm_req1_ready}); end
    req0_valid = 0; req1_valid = 0;
    step();
    tests++; if ({sm_rsp0_valid, sm_rsp_err, sm_hit0_count, sm_grant0_count} !== 6'b000001) begin fails++; $display("FAIL tmo_after: got rsp0=%b err=%b h0=%0d g0=%0d want 0,0,0,1", sm_rsp0_valid, sm_rsp_err, sm_hit0_count, sm_grant0_count); end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    cache_ready = 1;
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1;
      step();                                // ISSUE
      req0_valid = 0;
      step();                                // WAIT
      cache_done = 1; cache_hit = 1;
      step();                                // IDLE + response
      cache_done = 0; cache_hit = 0;
    end
    tests++; if ({sm_grant0_count, sm_hit0_count} !== 4'b1111) begin fails++; $display("FAIL sat_small: got g0=%0d h0=%0d want 3,3", sm_grant0_count, sm_hit0_count); end
    tests++; if ({grant0_count, hit0_count} !== {12'd5, 12'd5}) begin fails++; $display("FAIL sat_default: got g0=%0d h0=%0d want 5,5", grant0_count, hit0_count); end
    req0_valid = 1;
    step();                                  // ISSUE
    req0_valid = 0;
    step();                                  // WAIT
    reset = 1;
    step();
    reset = 0;
    cache_done = 1; cache_hit = 1;           // stale completion after reset
    tests++; if ({rsp0_valid, sm_rsp0_valid, cache_valid, grant0_count, sm_grant0_count, sm_hit0_count} !== 17'h0) begin fails++; $display("FAIL midop_reset: got rsp0=%b smrsp0=%b cv=%b g0=%0d smg0=%0d smh0=%0d want all 0", rsp0_valid, sm_rsp0_valid, cache_valid, grant0_count, sm_grant0_count, sm_hit0_count); end
    step();
    cache_done = 0; cache_hit = 0;
    tests++; if ({rsp0_valid, sm_rsp0_valid, hit0_count} !== 14'h0) begin fails++; $display("FAIL midop_no_rsp: got rsp0=%b smrsp0=%b h0=%0d want 0,0,0", rsp0_valid, sm_rsp0_valid, hit0_count); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_single_read();
    test_contention();
    test_backpressure();
    test_timeout();
    test_saturation_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
